// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared entry layout, widths and tag helpers for the multi-issue ROB
package rob_pkg;

  localparam int DEC_W    = 9;
  localparam int RES_W    = 70;
  localparam int TAG_NONE = 0;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [DEC_W-1:0] payload;
    logic [RES_W-1:0] result;
  } rob_entry_t;

  // Tags are 1-based so that 0 can mean "no entry"; callers truncate to index width.
  function automatic int unsigned tag2idx(input int unsigned tag);
    return tag - 1;
  endfunction

endpackage

// File: rtl/rob_ptr_ring.sv
// rtl/rob_ptr_ring.sv - circular pointer advancing by a small lane count, cleared on flush
module rob_ptr_ring #(
  parameter  int DEPTH   = 16,
  parameter  int MAX_INC = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int IW      = $clog2(MAX_INC + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic [IW-1:0] inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q, ptr_d;

  // DEPTH is a power of two, so the natural AW-bit wrap is the modulo.
  always_comb begin
    ptr_d = ptr_q + AW'(inc_i);
    if (clear_i) ptr_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_superscalar.sv
// rtl/rob_superscalar.sv - multi-issue reorder buffer: in-order dispatch, out-of-order completion, in-order retire
module rob_superscalar
  import rob_pkg::*;
#(
  parameter  int ROBsize    = 16,
  parameter  int DISPATCH_W = 2,
  parameter  int COMMIT_W   = 2,
  parameter  int NUM_CPL    = 2,
  localparam int ADDR_SIZE  = $clog2(ROBsize),
  localparam int TAG_W      = ADDR_SIZE + 1,
  localparam int LANE_W     = DEC_W + RES_W
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         needToRestore_i,
  input  logic [DISPATCH_W-1:0]        dispValid_i,
  input  logic [DISPATCH_W*DEC_W-1:0]  dispData_i,
  output logic [DISPATCH_W*TAG_W-1:0]  dispTag_o,
  output logic                         dispReady_o,
  input  logic [NUM_CPL-1:0]           cplValid_i,
  input  logic [NUM_CPL*TAG_W-1:0]     cplTag_i,
  input  logic [NUM_CPL*RES_W-1:0]     cplData_i,
  input  logic [TAG_W-1:0]             rdTag1_i,
  input  logic [TAG_W-1:0]             rdTag2_i,
  output logic [RES_W:0]               rdData1_o,
  output logic [RES_W:0]               rdData2_o,
  output logic [COMMIT_W-1:0]          commitValid_o,
  output logic [COMMIT_W*LANE_W-1:0]   commitData_o,
  input  logic                         commitReady_i,
  output logic [TAG_W-1:0]             head_o,
  output logic [TAG_W-1:0]             count_o,
  output logic                         empty_o
);

  localparam int MAX_INC = (DISPATCH_W > COMMIT_W) ? DISPATCH_W : COMMIT_W;
  localparam int IW      = $clog2(MAX_INC + 1);
  localparam logic [TAG_W-1:0] DISP_LIMIT = TAG_W'(ROBsize - DISPATCH_W);

  rob_entry_t              entries_q [ROBsize];
  rob_entry_t              entries_d [ROBsize];
  logic [TAG_W-1:0]        count_q, count_d;
  logic [ADDR_SIZE-1:0]    head_ptr, tail_ptr;
  logic [IW-1:0]           disp_cnt, ret_cnt;
  logic                    disp_ready;
  logic [COMMIT_W-1:0]     commit_valid;

  function automatic logic tag_ok(input logic [TAG_W-1:0] tag);
    return (32'(tag) != TAG_NONE) && (32'(tag) <= ROBsize);
  endfunction

  rob_ptr_ring #(.DEPTH(ROBsize), .MAX_INC(MAX_INC)) u_head (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (needToRestore_i),
    .inc_i   (ret_cnt),
    .ptr_o   (head_ptr)
  );

  rob_ptr_ring #(.DEPTH(ROBsize), .MAX_INC(MAX_INC)) u_tail (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (needToRestore_i),
    .inc_i   (disp_cnt),
    .ptr_o   (tail_ptr)
  );

  // Registered count only: entries freed this cycle are not offered until the next.
  assign disp_ready = (count_q <= DISP_LIMIT);
  assign disp_cnt   = disp_ready ? IW'($countones(dispValid_i)) : '0;
  assign ret_cnt    = commitReady_i ? IW'($countones(commit_valid)) : '0;

  always_comb begin
    logic [ADDR_SIZE-1:0] lane_idx;
    lane_idx  = '0;
    dispTag_o = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      lane_idx = tail_ptr + ADDR_SIZE'(k);
      dispTag_o[k*TAG_W +: TAG_W] = {1'b0, lane_idx} + TAG_W'(1);
    end
  end

  // Retire lanes form a prefix: a lane is offered only if every older lane is too.
  always_comb begin
    logic                 chain;
    logic [ADDR_SIZE-1:0] cidx;
    chain        = 1'b1;
    cidx         = '0;
    commit_valid = '0;
    commitData_o = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cidx            = head_ptr + ADDR_SIZE'(k);
      chain           = chain & entries_q[cidx].valid & entries_q[cidx].done;
      commit_valid[k] = chain;
      commitData_o[k*LANE_W +: LANE_W] = {entries_q[cidx].payload, entries_q[cidx].result};
    end
  end

  always_comb begin
    logic [ADDR_SIZE-1:0] idx;
    logic [TAG_W-1:0]     ctag;
    idx       = '0;
    ctag      = '0;
    entries_d = entries_q;
    count_d   = count_q + TAG_W'(disp_cnt) - TAG_W'(ret_cnt);
    if (needToRestore_i) begin
      count_d = '0;
      for (int i = 0; i < ROBsize; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end else begin
      // Ascending port order lets the higher port win a same-tag collision.
      for (int p = 0; p < NUM_CPL; p++) begin
        ctag = cplTag_i[p*TAG_W +: TAG_W];
        idx  = ADDR_SIZE'(tag2idx(32'(ctag)));
        if (cplValid_i[p] && tag_ok(ctag) && entries_q[idx].valid) begin
          entries_d[idx].done   = 1'b1;
          entries_d[idx].result = cplData_i[p*RES_W +: RES_W];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        idx = head_ptr + ADDR_SIZE'(k);
        if (commitReady_i && commit_valid[k]) begin
          entries_d[idx].valid = 1'b0;
          entries_d[idx].done  = 1'b0;
        end
      end
      for (int k = 0; k < DISPATCH_W; k++) begin
        idx = tail_ptr + ADDR_SIZE'(k);
        if (disp_ready && dispValid_i[k]) begin
          entries_d[idx].valid   = 1'b1;
          entries_d[idx].done    = 1'b0;
          entries_d[idx].payload = dispData_i[k*DEC_W +: DEC_W];
          entries_d[idx].result  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
      for (int i = 0; i < ROBsize; i++) entries_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  always_comb begin
    logic [ADDR_SIZE-1:0] r1, r2;
    r1        = ADDR_SIZE'(tag2idx(32'(rdTag1_i)));
    r2        = ADDR_SIZE'(tag2idx(32'(rdTag2_i)));
    rdData1_o = '0;
    rdData2_o = '0;
    if (tag_ok(rdTag1_i) && entries_q[r1].valid) rdData1_o = {entries_q[r1].done, entries_q[r1].result};
    if (tag_ok(rdTag2_i) && entries_q[r2].valid) rdData2_o = {entries_q[r2].done, entries_q[r2].result};
  end

  assign commitValid_o = commit_valid;
  assign dispReady_o   = disp_ready;
  assign head_o        = {1'b0, head_ptr} + TAG_W'(1);
  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);

endmodule

// File: tb/tb_rob_superscalar.sv
// tb/tb_rob_superscalar.sv - directed bench with an in-order queue model of the ROB
module tb_rob_superscalar;

  localparam int RS   = 8;
  localparam int DECW = 9;
  localparam int RESW = 70;

  typedef struct {
    int             tag;
    logic [8:0]     pay;
    bit             done;
    logic [69:0]    res;
  } ment_t;

  logic         clk;
  logic         reset_i;
  logic         needToRestore_i;
  logic [1:0]   dispValid_i;
  logic [17:0]  dispData_i;
  logic [7:0]   dispTag_o;
  logic         dispReady_o;
  logic [1:0]   cplValid_i;
  logic [7:0]   cplTag_i;
  logic [139:0] cplData_i;
  logic [3:0]   rdTag1_i, rdTag2_i;
  logic [70:0]  rdData1_o, rdData2_o;
  logic [1:0]   commitValid_o;
  logic [157:0] commitData_o;
  logic         commitReady_i;
  logic [3:0]   head_o, count_o;
  logic         empty_o;

  int     n_checks;
  int     n_fails;
  ment_t  mq[$];
  int     m_head;
  ment_t  m_new;

  rob_superscalar #(.ROBsize(RS), .DISPATCH_W(2), .COMMIT_W(2), .NUM_CPL(2)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .needToRestore_i (needToRestore_i),
    .dispValid_i     (dispValid_i),
    .dispData_i      (dispData_i),
    .dispTag_o       (dispTag_o),
    .dispReady_o     (dispReady_o),
    .cplValid_i      (cplValid_i),
    .cplTag_i        (cplTag_i),
    .cplData_i       (cplData_i),
    .rdTag1_i        (rdTag1_i),
    .rdTag2_i        (rdTag2_i),
    .rdData1_o       (rdData1_o),
    .rdData2_o       (rdData2_o),
    .commitValid_o   (commitValid_o),
    .commitData_o    (commitData_o),
    .commitReady_i   (commitReady_i),
    .head_o          (head_o),
    .count_o         (count_o),
    .empty_o         (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset_i) assert (dispValid_i != 2'b10) else $error("non-contiguous dispValid_i");

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_cv();
    logic [1:0] r;
    bit run;
    r   = 2'b00;
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (run && k < mq.size() && mq[k].done) r[k] = 1'b1;
      else run = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [70:0] m_rd(input logic [3:0] tag);
    foreach (mq[i]) if (mq[i].tag == int'(tag)) return {mq[i].done, mq[i].res};
    return 71'd0;
  endfunction

  task automatic compare_model();
    int sz;
    logic [1:0] cv;
    sz = mq.size();
    cv = m_cv();
    chk("m_count", 160'(count_o), 160'(sz));
    chk("m_empty", 160'(empty_o), 160'(sz == 0));
    chk("m_head", 160'(head_o), 160'(m_head + 1));
    chk("m_ready", 160'(dispReady_o), 160'(RS - sz >= 2));
    chk("m_tag0", 160'(dispTag_o[3:0]), 160'(((m_head + sz) % RS) + 1));
    chk("m_tag1", 160'(dispTag_o[7:4]), 160'(((m_head + sz + 1) % RS) + 1));
    chk("m_cvalid", 160'(commitValid_o), 160'(cv));
    if (cv[0]) chk("m_cdata0", 160'(commitData_o[78:0]), 160'({mq[0].pay, mq[0].res}));
    if (cv[1]) chk("m_cdata1", 160'(commitData_o[157:79]), 160'({mq[1].pay, mq[1].res}));
    chk("m_rd1", 160'(rdData1_o), 160'(m_rd(rdTag1_i)));
    chk("m_rd2", 160'(rdData2_o), 160'(m_rd(rdTag2_i)));
  endtask

  // Inputs are stable from posedge+1 until the next posedge+1, so at the
  // falling edge they are exactly what the coming rising edge will sample.
  task automatic model_step();
    int sz, tl, nd, nret;
    sz   = mq.size();
    tl   = (m_head + sz) % RS;
    nd   = (RS - sz >= 2) ? $countones(dispValid_i) : 0;
    nret = commitReady_i ? $countones(m_cv()) : 0;
    if (needToRestore_i) begin
      mq.delete();
      m_head = 0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (cplValid_i[p])
          foreach (mq[i])
            if (mq[i].tag == int'(cplTag_i[p*4 +: 4])) begin
              mq[i].done = 1'b1;
              mq[i].res  = cplData_i[p*RESW +: RESW];
            end
      repeat (nret) void'(mq.pop_front());
      m_head = (m_head + nret) % RS;
      for (int k = 0; k < nd; k++) begin
        m_new.tag  = ((tl + k) % RS) + 1;
        m_new.pay  = dispData_i[k*DECW +: DECW];
        m_new.done = 1'b0;
        m_new.res  = '0;
        mq.push_back(m_new);
      end
    end
  endtask

  initial begin
    mq.delete();
    m_head = 0;
    forever begin
      @(negedge clk);
      compare_model();
      if (!reset_i) begin
        mq.delete();
        m_head = 0;
      end else begin
        model_step();
      end
    end
  end

  task automatic idle();
    dispValid_i     = 2'b00;
    cplValid_i      = 2'b00;
    commitReady_i   = 1'b0;
    needToRestore_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [1:0] v, input logic [8:0] p0, input logic [8:0] p1);
    dispValid_i = v;
    dispData_i  = {p1, p0};
  endtask

  task automatic cpl(input int port, input logic [3:0] tag, input logic [69:0] data);
    cplValid_i[port]          = 1'b1;
    cplTag_i[port*4 +: 4]     = tag;
    cplData_i[port*RESW +: RESW] = data;
  endtask

  task automatic fill();
    for (int c = 0; c < 4; c++) begin
      disp(2'b11, 9'(2*c + 1), 9'(2*c + 2));
      #2;
      chk("fill_tag0", 160'(dispTag_o[3:0]), 160'(2*c + 1));
      chk("fill_tag1", 160'(dispTag_o[7:4]), 160'(2*c + 2));
      tick();
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_i  = 1'b0;
    idle();
    dispData_i = '0;
    cplTag_i   = '0;
    cplData_i  = '0;
    rdTag1_i   = '0;
    rdTag2_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    #2;
    chk("rst_count", 160'(count_o), 160'(0));
    chk("rst_empty", 160'(empty_o), 160'(1));
    chk("rst_head", 160'(head_o), 160'(1));
    chk("rst_cvalid", 160'(commitValid_o), 160'(0));
    chk("rst_ready", 160'(dispReady_o), 160'(1));
    reset_i = 1'b1;
    tick();

    fill();
    #2;
    chk("full_count", 160'(count_o), 160'(8));
    chk("full_ready", 160'(dispReady_o), 160'(0));
    disp(2'b11, 9'd9, 9'd10);
    tick();
    idle();
    #2;
    chk("full_ignored", 160'(count_o), 160'(8));

    cpl(0, 4'd2, 70'h22);
    #2;
    chk("ooo_cv_a", 160'(commitValid_o), 160'(0));
    tick();
    idle();
    cpl(0, 4'd1, 70'h11);
    #2;
    chk("ooo_cv_b", 160'(commitValid_o), 160'(0));
    tick();
    idle();
    #2;
    chk("ooo_cv_c", 160'(commitValid_o), 160'(2'b11));
    chk("ooo_data0", 160'(commitData_o[78:0]), 160'({9'd1, 70'h11}));
    chk("ooo_data1", 160'(commitData_o[157:79]), 160'({9'd2, 70'h22}));
    commitReady_i = 1'b1;
    tick();
    idle();
    #2;
    chk("retire_head", 160'(head_o), 160'(3));
    chk("retire_count", 160'(count_o), 160'(6));

    commitReady_i = 1'b1;
    cpl(0, 4'd3, 70'h33);
    cpl(1, 4'd4, 70'h44);
    tick();
    cpl(0, 4'd5, 70'h55);
    cpl(1, 4'd6, 70'h66);
    tick();
    cplValid_i = 2'b00;
    tick();
    idle();
    #2;
    chk("wrap_head", 160'(head_o), 160'(7));
    chk("wrap_count", 160'(count_o), 160'(2));
    chk("wrap_tag0", 160'(dispTag_o[3:0]), 160'(1));
    chk("wrap_tag1", 160'(dispTag_o[7:4]), 160'(2));
    disp(2'b11, 9'd11, 9'd12);
    tick();
    idle();
    cpl(0, 4'd8, 70'h88);
    cpl(1, 4'd1, 70'h101);
    tick();
    idle();
    #2;
    chk("wrap_cv_a", 160'(commitValid_o), 160'(0));
    cpl(0, 4'd7, 70'h77);
    tick();
    idle();
    #2;
    chk("wrap_cv_b", 160'(commitValid_o), 160'(2'b11));
    chk("wrap_data7", 160'(commitData_o[78:0]), 160'({9'd7, 70'h77}));
    chk("wrap_data8", 160'(commitData_o[157:79]), 160'({9'd8, 70'h88}));
    commitReady_i = 1'b1;
    tick();
    idle();
    #2;
    chk("wrap_cv_c", 160'(commitValid_o), 160'(2'b01));
    chk("wrap_data1", 160'(commitData_o[78:0]), 160'({9'd11, 70'h101}));
    commitReady_i = 1'b1;
    tick();
    idle();
    #2;
    chk("wrap_head2", 160'(head_o), 160'(2));
    chk("wrap_count2", 160'(count_o), 160'(1));

    disp(2'b11, 9'd13, 9'd14);
    tick();
    idle();
    rdTag1_i = 4'd3;
    #2;
    chk("rd_pending", 160'(rdData1_o), 160'({1'b0, 70'h0}));
    cpl(0, 4'd3, 70'hA);
    cpl(1, 4'd3, 70'hB);
    tick();
    idle();
    #2;
    chk("rd_collide", 160'(rdData1_o), 160'({1'b1, 70'hB}));
    cpl(0, 4'd6, 70'h666);
    cpl(1, 4'd0, 70'h999);
    rdTag2_i = 4'd6;
    tick();
    idle();
    #2;
    chk("rd_dropped", 160'(rdData2_o), 160'(0));
    rdTag2_i = 4'd0;
    #1;
    chk("rd_tag0", 160'(rdData2_o), 160'(0));

    needToRestore_i = 1'b1;
    disp(2'b11, 9'd20, 9'd21);
    cpl(0, 4'd2, 70'h5);
    commitReady_i = 1'b1;
    #2;
    chk("flush_same_cycle", 160'(count_o), 160'(3));
    tick();
    idle();
    #2;
    chk("flush_count", 160'(count_o), 160'(0));
    chk("flush_head", 160'(head_o), 160'(1));
    chk("flush_empty", 160'(empty_o), 160'(1));
    chk("flush_cv", 160'(commitValid_o), 160'(0));
    chk("flush_rd", 160'(rdData1_o), 160'(0));

    fill();
    cpl(0, 4'd1, 70'h1);
    cpl(1, 4'd2, 70'h2);
    tick();
    idle();
    commitReady_i = 1'b1;
    disp(2'b11, 9'd30, 9'd31);
    tick();
    idle();
    #2;
    chk("full_commit_count", 160'(count_o), 160'(6));
    chk("full_commit_ready", 160'(dispReady_o), 160'(1));
    cpl(0, 4'd3, 70'h3);
    cpl(1, 4'd4, 70'h4);
    tick();
    idle();
    commitReady_i = 1'b1;
    disp(2'b11, 9'd32, 9'd33);
    #2;
    chk("both_tag0", 160'(dispTag_o[3:0]), 160'(1));
    tick();
    idle();
    #2;
    chk("both_count", 160'(count_o), 160'(6));
    chk("both_head", 160'(head_o), 160'(5));
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
